// File: rtl/sdm_stream_ctrl_if.sv
// Sample-stream handshake between the sample producer and sdm_stream_ctrl.
// master: drives samples; slave: the scheduler's FIFO write side.
interface sdm_stream_ctrl_if #(
   parameter int unsigned DW = 16
) ();
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sdm_stream_ctrl.sv
// Sample scheduler for the 2nd-order sigma-delta modulator and its decimator.
// Buffers samples in a small FIFO, holds each on sdm_din for OSR clocks and captures the
// decimator word at every frame boundary once SETTLE frames have passed.
// Build option: define SDM_STREAM_ZERO_FILL_EN to drive 0 on underrun instead of holding
// the previous sample.
module sdm_stream_ctrl #(
   parameter int unsigned DW         = 16,
   parameter int unsigned OSR        = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SETTLE     = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   sdm_stream_ctrl_if.slave       s_if,
   output logic [DW-1:0]          sdm_din,
   input  logic [DW-1:0]          dec_in,
   output logic                   frame_tick,
   output logic [DW-1:0]          cap_data,
   output logic                   cap_valid,
   output logic                   underrun,
   output logic                   busy
);

   localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned CW   = $clog2(OSR);
   localparam int unsigned SW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [DW-1:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [DW-1:0]   din_q, din_d;
   logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [DW-1:0]   cap_data_q, cap_data_d;
   logic            cap_valid_q, cap_valid_d;
   logic            underrun_q, underrun_d;
   logic            full, empty, push, pop, tick;

   assign full       = (count_q == CNTW'(FIFO_DEPTH));
   assign empty      = (count_q == '0);
   assign push       = s_if.s_valid && !full;
   assign tick       = (state_q == StRun) && (frame_cnt_q == CW'(OSR - 1));

   assign s_if.s_ready = !full;
   assign sdm_din      = din_q;
   assign frame_tick   = tick;
   assign cap_data     = cap_data_q;
   assign cap_valid    = cap_valid_q;
   assign underrun     = underrun_q;
   assign busy         = (state_q != StIdle);

   // FIFO write side and occupancy; pop is decided by the FSM from the pre-edge count,
   // so a pop from an empty FIFO can never see the same cycle's push.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = s_if.s_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNTW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNTW'(1);
      end
   end

   // Scheduler FSM: frame counting, sample hand-off, capture and underrun detection.
   always_comb begin
      state_d     = state_q;
      din_d       = din_q;
      frame_cnt_d = frame_cnt_q;
      settle_d    = settle_q;
      cap_data_d  = cap_data_q;
      cap_valid_d = 1'b0;
      underrun_d  = underrun_q;
      pop         = 1'b0;
      unique case (state_q)
         StIdle: begin
            din_d = '0;
            if (en) begin
               state_d = StPrime;
            end
         end
         StPrime: begin
            if (!en) begin
               state_d = StIdle;
            end else if (!empty) begin
               pop         = 1'b1;
               din_d       = mem_q[rd_ptr_q];
               frame_cnt_d = '0;
               settle_d    = '0;
               state_d     = StRun;
            end
         end
         StRun: begin
            frame_cnt_d = tick ? '0 : frame_cnt_q + CW'(1);
            if (tick) begin
               cap_data_d  = dec_in;
               cap_valid_d = (settle_q >= SW'(SETTLE));
               if (settle_q < SW'(SETTLE)) begin
                  settle_d = settle_q + SW'(1);
               end
               if (!en) begin
                  din_d   = '0;
                  state_d = StIdle;
               end else if (!empty) begin
                  pop   = 1'b1;
                  din_d = mem_q[rd_ptr_q];
               end else begin
                  underrun_d = 1'b1;
`ifdef SDM_STREAM_ZERO_FILL_EN
                  din_d = '0;
`else
                  din_d = din_q;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO storage; contents are don't-care until written, so no reset is needed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control state with synchronous reset; reset wins over any capture on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         din_q       <= '0;
         frame_cnt_q <= '0;
         settle_q    <= '0;
         cap_data_q  <= '0;
         cap_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         din_q       <= din_d;
         frame_cnt_q <= frame_cnt_d;
         settle_q    <= settle_d;
         cap_data_q  <= cap_data_d;
         cap_valid_q <= cap_valid_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_sdm_stream_ctrl.sv
// Self-checking bench for sdm_stream_ctrl (OSR=8, FIFO_DEPTH=4, SETTLE=2, DW=16).
// A queue-based reference model predicts every output each cycle; directed scenarios
// are followed by a randomized soak.
module tb_sdm_stream_ctrl;

   localparam int unsigned DW     = 16;
   localparam int unsigned OSR    = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned SETTLE = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [DW-1:0] dec_in;
   logic [DW-1:0] sdm_din, cap_data;
   logic          frame_tick, cap_valid, underrun, busy;

   sdm_stream_ctrl_if #(.DW(DW)) s_if ();

   sdm_stream_ctrl #(
      .DW(DW), .OSR(OSR), .FIFO_DEPTH(DEPTH), .SETTLE(SETTLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .s_if       (s_if.slave),
      .sdm_din    (sdm_din),
      .dec_in     (dec_in),
      .frame_tick (frame_tick),
      .cap_data   (cap_data),
      .cap_valid  (cap_valid),
      .underrun   (underrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] mq [$];
   bit            m_prime, m_run;
   int            m_pos, m_frames;
   logic [DW-1:0] m_din, m_cap_data;
   bit            m_cap_valid, m_underrun;
   bit            dec_follow = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_prime = 0; m_run = 0; m_pos = 0; m_frames = 0;
      m_din = '0; m_cap_data = '0; m_cap_valid = 0; m_underrun = 0;
   endtask

   // One clock edge of the specified behaviour, using the inputs present before the edge.
   task automatic model_step();
      bit do_push;
      if (rst) begin
         model_reset();
         return;
      end
      do_push     = s_if.s_valid && (mq.size() < DEPTH);
      m_cap_valid = 0;
      if (m_run) begin
         if (m_pos == OSR - 1) begin
            m_cap_data  = dec_in;
            m_cap_valid = (m_frames >= SETTLE);
            m_frames++;
            m_pos = 0;
            if (!en) begin
               m_din = '0;
               m_run = 0;
            end else if (mq.size() > 0) begin
               m_din = mq.pop_front();
            end else begin
               m_underrun = 1;
`ifdef SDM_STREAM_ZERO_FILL_EN
               m_din = '0;
`endif
            end
         end else begin
            m_pos++;
         end
      end else if (m_prime) begin
         if (!en) begin
            m_prime = 0;
         end else if (mq.size() > 0) begin
            m_din    = mq.pop_front();
            m_prime  = 0;
            m_run    = 1;
            m_pos    = 0;
            m_frames = 0;
         end
      end else if (en) begin
         m_prime = 1;
      end
      if (do_push) mq.push_back(s_if.s_data);
   endtask

   task automatic compare_all();
      check_eq("s_ready",    32'(s_if.s_ready), 32'(mq.size() < DEPTH));
      check_eq("sdm_din",    32'(sdm_din),      32'(m_din));
      check_eq("frame_tick", 32'(frame_tick),   32'(m_run && m_pos == OSR - 1));
      check_eq("cap_data",   32'(cap_data),     32'(m_cap_data));
      check_eq("cap_valid",  32'(cap_valid),    32'(m_cap_valid));
      check_eq("underrun",   32'(underrun),     32'(m_underrun));
      check_eq("busy",       32'(busy),         32'(m_prime || m_run));
   endtask

   // Inputs are set at the falling edge; the model steps after the rising edge.
   task automatic cycle();
      if (dec_follow) dec_in = DW'(m_frames);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic push_one(input logic [DW-1:0] d);
      s_if.s_valid = 1'b1;
      s_if.s_data  = d;
      cycle();
      s_if.s_valid = 1'b0;
   endtask

   task automatic run_to_pos(input int pos);
      for (int i = 0; i < 2 * OSR && !(m_run && m_pos == pos); i++) cycle();
   endtask

`ifdef SDM_STREAM_ZERO_FILL_EN
   localparam logic [DW-1:0] UnderrunDin = 16'h0000;
`else
   localparam logic [DW-1:0] UnderrunDin = 16'hC000;
`endif

   initial begin
      model_reset();
      rst = 1'b1; en = 1'b0; dec_in = '0;
      s_if.s_valid = 1'b0; s_if.s_data = '0;
      @(negedge clk);
      cycle();
      rst = 1'b0;
      check_eq("rst_sdm_din",   32'(sdm_din), 32'h0);
      check_eq("rst_s_ready",   32'(s_if.s_ready), 32'h1);
      check_eq("rst_cap_valid", 32'(cap_valid), 32'h0);
      check_eq("rst_underrun",  32'(underrun), 32'h0);
      check_eq("rst_busy",      32'(busy), 32'h0);

      // Fill with en low: stays idle, FIFO full after four pushes
      for (int i = 0; i < 4; i++) push_one(DW'(16'h1111 * (i + 1)));
      check_eq("full_s_ready", 32'(s_if.s_ready), 32'h0);
      check_eq("idle_busy",    32'(busy), 32'h0);
      check_eq("idle_sdm_din", 32'(sdm_din), 32'h0);

      rst = 1'b1; cycle(); rst = 1'b0;
      push_one(16'h4000); push_one(16'h2000); push_one(16'hC000);
      dec_follow = 1'b1;
      en = 1'b1;
      cycle(); cycle();
      check_eq("first_sample", 32'(sdm_din), 32'h4000);
      repeat (7) cycle();
      check_eq("tick_frame0", 32'(frame_tick), 32'h1);
      cycle();
      check_eq("second_sample", 32'(sdm_din), 32'h2000);
      check_eq("no_cap_frame0", 32'(cap_valid), 32'h0);
      repeat (8) cycle();
      check_eq("third_sample", 32'(sdm_din), 32'hC000);
      check_eq("no_cap_frame1", 32'(cap_valid), 32'h0);
      repeat (8) cycle();
      check_eq("underrun_set", 32'(underrun), 32'h1);
      check_eq("underrun_din", 32'(sdm_din), 32'(UnderrunDin));
      check_eq("cap_frame2_v", 32'(cap_valid), 32'h1);
      check_eq("cap_frame2_d", 32'(cap_data), 32'h2);
      push_one(16'h1000);
      repeat (7) cycle();
      check_eq("refill_din",    32'(sdm_din), 32'h1000);
      check_eq("cap_frame3_d",  32'(cap_data), 32'h3);
      check_eq("underrun_kept", 32'(underrun), 32'h1);

      // Drop en mid-frame: frame completes, then idle with FIFO retained
      push_one(16'h0AAA); push_one(16'h0BBB);
      run_to_pos(3);
      en = 1'b0;
      run_to_pos(7);
      check_eq("en_drop_hold", 32'(sdm_din), 32'h1000);
      cycle();
      check_eq("en_drop_zero", 32'(sdm_din), 32'h0);
      check_eq("en_drop_idle", 32'(busy), 32'h0);
      en = 1'b1;
      cycle(); cycle();
      check_eq("retained_head", 32'(sdm_din), 32'h0AAA);

      // Fill to full while running, then reset mid-frame
      for (int i = 0; i < 3 * OSR; i++) begin
         s_if.s_valid = 1'b1;
         s_if.s_data  = DW'($urandom);
         cycle();
      end
      s_if.s_valid = 1'b0;
      run_to_pos(5);
      rst = 1'b1; cycle(); rst = 1'b0;
      check_eq("midrst_din",   32'(sdm_din), 32'h0);
      check_eq("midrst_busy",  32'(busy), 32'h0);
      check_eq("midrst_under", 32'(underrun), 32'h0);
      check_eq("midrst_cap",   32'(cap_data), 32'h0);
      check_eq("midrst_ready", 32'(s_if.s_ready), 32'h1);

      // Randomized soak
      dec_follow = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         s_if.s_valid = ($urandom_range(0, 6) == 0);
         s_if.s_data  = DW'($urandom);
         dec_in       = DW'($urandom);
         if ($urandom_range(0, 39) == 0) en = ~en;
         rst = ($urandom_range(0, 799) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run can never hang
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
